duty_cycle_ctrl: RTL and testbench

Programmable duty-cycle (PWM) generator with a run controller. It replaces the fixed 1-of-4 waveform with a runtime-configurable period and high time. New settings are loaded through a valid/ready handshake and applied only on period boundaries, so no runt pulses occur. Disabling the block lets the current period finish before it goes idle.

---
 rtl/duty_cycle_pkg.sv | 12 +
 rtl/duty_cycle_cfg_slot.sv | 58 +++++
 rtl/duty_cycle_ctrl.sv | 95 +++++++++
 tb/tb_duty_cycle_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/duty_cycle_pkg.sv
// Shared types and defaults for the duty-cycle generator.
package duty_cycle_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } state_t;

  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/duty_cycle_cfg_slot.sv
// One-entry config holding slot: validates and clamps offers, pulses cfg_err on rejects.
// Ready is the inverse of occupancy; a zero-period offer is dropped without filling the slot.
module duty_cycle_cfg_slot
  import duty_cycle_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_cfg_valid,
  input  logic [CNT_W-1:0] i_cfg_period,
  input  logic [CNT_W-1:0] i_cfg_high,
  input  logic             i_take,
  output logic             o_cfg_ready,
  output logic             o_pend_valid,
  output logic [CNT_W-1:0] o_pend_period,
  output logic [CNT_W-1:0] o_pend_high,
  output logic             o_cfg_err
);

  logic             r_pend_valid;
  logic [CNT_W-1:0] r_pend_period;
  logic [CNT_W-1:0] r_pend_high;
  logic             r_cfg_err;
  logic             w_xfer;
  logic             w_reject;
  logic [CNT_W-1:0] w_high_clamped;

  assign w_xfer         = i_cfg_valid && !r_pend_valid;
  assign w_reject       = w_xfer && (i_cfg_period == '0);
  assign w_high_clamped = (i_cfg_high > i_cfg_period) ? i_cfg_period : i_cfg_high;

  // take and accept never coincide: take needs a full slot, accept an empty one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_valid  <= 1'b0;
      r_pend_period <= '0;
      r_pend_high   <= '0;
      r_cfg_err     <= 1'b0;
    end else begin
      r_cfg_err <= w_reject;
      if (i_take) begin
        r_pend_valid <= 1'b0;
      end else if (w_xfer && !w_reject) begin
        r_pend_valid  <= 1'b1;
        r_pend_period <= i_cfg_period;
        r_pend_high   <= w_high_clamped;
      end
    end
  end

  assign o_cfg_ready   = !r_pend_valid;
  assign o_pend_valid  = r_pend_valid;
  assign o_pend_period = r_pend_period;
  assign o_pend_high   = r_pend_high;
  assign o_cfg_err     = r_cfg_err;

endmodule

// File: rtl/duty_cycle_ctrl.sv
// Runtime-configurable PWM generator; new settings take effect only on period boundaries.
// Outputs are decoded from registers; dropping en finishes the current period before idling.
module duty_cycle_ctrl
  import duty_cycle_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int DEF_PERIOD = 4,
  parameter int DEF_HIGH   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             out,
  output logic             period_done,
  output logic             busy,
  output logic             cfg_err
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_act_period;
  logic [CNT_W-1:0] r_act_high;
  logic             w_wrap;
  logic             w_take;
  logic             w_pend_valid;
  logic [CNT_W-1:0] w_pend_period;
  logic [CNT_W-1:0] w_pend_high;

  duty_cycle_cfg_slot #(.CNT_W(CNT_W)) u_cfg_slot (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_cfg_valid  (cfg_valid),
    .i_cfg_period (cfg_period),
    .i_cfg_high   (cfg_high),
    .i_take       (w_take),
    .o_cfg_ready  (cfg_ready),
    .o_pend_valid (w_pend_valid),
    .o_pend_period(w_pend_period),
    .o_pend_high  (w_pend_high),
    .o_cfg_err    (cfg_err)
  );

  assign w_wrap = (r_cnt == r_act_period - CNT_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_take      = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        w_take    = w_pend_valid;
        if (en) w_state_nxt = RUN;
      end
      RUN, DRAIN: begin
        w_cnt_nxt = w_wrap ? '0 : r_cnt + CNT_W'(1);
        w_take    = w_wrap && w_pend_valid;
        // only a drain that reaches its wrap with en still low stops
        if (r_state == DRAIN && w_wrap && !en) w_state_nxt = IDLE;
        else                                   w_state_nxt = en ? RUN : DRAIN;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_act_period <= CNT_W'(DEF_PERIOD);
      r_act_high   <= CNT_W'(DEF_HIGH);
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_take) begin
        r_act_period <= w_pend_period;
        r_act_high   <= w_pend_high;
      end
    end
  end

  assign busy        = (r_state != IDLE);
  assign out         = busy && (r_cnt < r_act_high);
  assign period_done = busy && w_wrap;

endmodule

// File: tb/tb_duty_cycle_ctrl.sv
// Directed plus randomized bench for duty_cycle_ctrl against a cycle-level behavioural model.
module tb_duty_cycle_ctrl;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_period = '0;
  logic [CNT_W-1:0] cfg_high = '0;
  logic             out;
  logic             period_done;
  logic             busy;
  logic             cfg_err;

  int checks = 0;
  int failures = 0;

  // model: running flag, position within the period, settings, one-deep pending slot
  bit m_active, m_stopping, m_pv, m_err;
  int m_phase, m_ap, m_ah, m_pp, m_ph;

  duty_cycle_ctrl #(.CNT_W(CNT_W), .DEF_PERIOD(4), .DEF_HIGH(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .out        (out),
    .period_done(period_done),
    .busy       (busy),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_stopping = 0; m_pv = 0; m_err = 0;
    m_phase = 0; m_ap = 4; m_ah = 1; m_pp = 0; m_ph = 0;
  endtask

  task automatic model_edge();
    bit accept, at_end, apply;
    int p, h;
    p = int'(cfg_period);
    h = int'(cfg_high);
    accept = cfg_valid && !m_pv;
    at_end = m_active && (m_phase == m_ap - 1);
    apply  = m_pv && (!m_active || at_end);
    if (!m_active) begin
      m_phase = 0;
      if (en) begin m_active = 1; m_stopping = 0; end
    end else begin
      if (at_end && m_stopping && !en) m_active = 0;
      m_phase = (at_end || !m_active) ? 0 : m_phase + 1;
      m_stopping = !en;
    end
    if (apply) begin m_ap = m_pp; m_ah = m_ph; m_pv = 0; end
    m_err = accept && (p == 0);
    if (accept && p != 0) begin
      m_pv = 1; m_pp = p; m_ph = (h > p) ? p : h;
    end
  endtask

  task automatic check_outputs();
    chk("out",         out,         m_active && (m_phase < m_ah));
    chk("period_done", period_done, m_active && (m_phase == m_ap - 1));
    chk("busy",        busy,        m_active);
    chk("cfg_ready",   cfg_ready,   !m_pv);
    chk("cfg_err",     cfg_err,     m_err);
  endtask

  // inputs are changed only at the falling edge; outputs are compared there too
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send_cfg(input int p, input int h);
    cfg_valid = 1'b1; cfg_period = CNT_W'(p); cfg_high = CNT_W'(h);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_phase(input string tag, input int ph);
    bit found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      if (m_active && m_phase == ph) found = 1;
      else tick();
    end
    chk(tag, found, 1'b1);
  endtask

  initial begin
    bit legacy [4];
    legacy[0] = 1; legacy[1] = 0; legacy[2] = 0; legacy[3] = 0;
    model_reset();

    // reset defaults
    #12;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("legacy_out", out, legacy[i % 4]);
      chk("legacy_pd", period_done, (i % 4) == 3);
    end

    // mid-period reconfig at cnt=1
    wait_phase("wait_cnt1", 1);
    send_cfg(5, 2);
    chk("reconfig_ready_low", cfg_ready, 1'b0);
    for (int i = 0; i < 14; i++) tick();

    // reject then clamp
    send_cfg(0, 3);
    chk("reject_err", cfg_err, 1'b1);
    tick();
    chk("reject_err_gone", cfg_err, 1'b0);
    send_cfg(3, 9);
    for (int i = 0; i < 14; i++) tick();

    // drain to idle, then drain with resume
    send_cfg(4, 1);
    for (int i = 0; i < 8; i++) tick();
    wait_phase("wait_drain", 1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("drain_idle", busy, 1'b0);
    tick();
    en = 1'b1;
    wait_phase("wait_resume", 1);
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    tick();
    chk("resume_busy", busy, 1'b1);
    chk("resume_out", out, 1'b1);

    // async reset while out is high
    wait_phase("wait_rst", 0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_out", out, 1'b0);
    chk("async_busy", busy, 1'b0);
    model_reset();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();

    // config accepted on the wrap edge, then period 1
    wait_phase("wait_wrap", 3);
    send_cfg(6, 4);
    for (int i = 0; i < 16; i++) tick();
    send_cfg(1, 1);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i > 8) begin
        chk("p1_out", out, 1'b1);
        chk("p1_pd", period_done, 1'b1);
      end
    end

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) en = ~en;
      cfg_valid  = ($urandom_range(0, 5) == 0);
      cfg_period = CNT_W'($urandom_range(0, 7));
      cfg_high   = CNT_W'($urandom_range(0, 9));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
